// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and constants for the UART memory bridge: FSM encoding, packet
// lengths and the packet byte selector.
package uart_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_RX   = 2'd2,
    ST_RESP_DONE = 2'd3
  } state_t;

  localparam int HDR_WE_BIT = 4;
  localparam int PKT_LEN_WR = 9;
  localparam int PKT_LEN_RD = 5;
  localparam int RESP_LEN   = 4;

  // Byte idx of the outgoing packet: header, addr LSB first, then wdata LSB first.
  function automatic logic [7:0] pkt_byte(
    input logic [3:0]  idx,
    input logic        we,
    input logic [3:0]  mask,
    input logic [31:0] addr,
    input logic [31:0] wdata
  );
    logic [7:0] hdr;
    logic [7:0] b;
    hdr             = 8'h00;
    hdr[HDR_WE_BIT] = we;
    hdr[3:0]        = mask;
    case (idx)
      4'd0:    b = hdr;
      4'd1:    b = addr[7:0];
      4'd2:    b = addr[15:8];
      4'd3:    b = addr[23:16];
      4'd4:    b = addr[31:24];
      4'd5:    b = wdata[7:0];
      4'd6:    b = wdata[15:8];
      4'd7:    b = wdata[23:16];
      4'd8:    b = wdata[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_mem_bridge.sv
// Packet layer between a CPU memory port and the uart_trans FIFOs: serialises one
// request into a byte packet and, for reads, reassembles the 4-byte reply.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [3:0]  i_req_mask,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_tx_send_flag,
  output logic [7:0]  o_tx_send_data,
  input  logic        i_tx_sendable,
  output logic        o_rx_recv_flag,
  input  logic [7:0]  i_rx_recv_data,
  input  logic        i_rx_receivable
);

  localparam int TW           = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_we;
  logic [3:0]      r_mask;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_idx;
  logic [TW-1:0]   r_timer;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            w_tx_send_flag;
  logic            w_rx_recv_flag;
  logic            w_timeout;
  logic [3:0]      w_pkt_last;

  assign w_pkt_last = r_we ? 4'(PKT_LEN_WR - 1) : 4'(PKT_LEN_RD - 1);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_timer == TW'(TIMEOUT_LAST));

  always_comb begin
    w_state_next   = r_state;
    w_tx_send_flag = 1'b0;
    w_rx_recv_flag = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Drain stray/late reply bytes so the next read starts aligned.
        w_rx_recv_flag = i_rx_receivable;
        if (i_req_valid) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        w_tx_send_flag = i_tx_sendable;
        if (i_tx_sendable && (r_idx == w_pkt_last))
          w_state_next = r_we ? ST_RESP_DONE : ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        w_rx_recv_flag = i_rx_receivable;
        if (i_rx_receivable && (r_idx == 4'(RESP_LEN - 1))) w_state_next = ST_RESP_DONE;
        else if (!i_rx_receivable && w_timeout)              w_state_next = ST_RESP_DONE;
      end
      ST_RESP_DONE: w_state_next = ST_IDLE;
      default:      w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_mask  <= 4'h0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_idx   <= 4'd0;
      r_timer <= '0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_we    <= i_req_we;
            r_mask  <= i_req_mask;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
            r_idx   <= 4'd0;
            r_timer <= '0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
          end
        end
        ST_SEND: begin
          if (w_tx_send_flag)
            r_idx <= (r_idx == w_pkt_last) ? 4'd0 : r_idx + 4'd1;
        end
        ST_WAIT_RX: begin
          if (w_rx_recv_flag) begin
            r_rdata <= {i_rx_recv_data, r_rdata[31:8]};
            r_idx   <= r_idx + 4'd1;
            r_timer <= '0;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_req_ready    = (r_state == ST_IDLE);
  assign o_resp_valid   = (r_state == ST_RESP_DONE);
  assign o_resp_rdata   = o_resp_valid ? r_rdata : 32'h0;
  assign o_resp_err     = o_resp_valid & r_err;
  assign o_tx_send_flag = w_tx_send_flag;
  assign o_tx_send_data = pkt_byte(r_idx, r_we, r_mask, r_addr, r_wdata);
  // Never pop the receive FIFO while held in reset.
  assign o_rx_recv_flag = w_rx_recv_flag & i_rst_n;

endmodule
